// File: rtl/pipe_reg_elastic.sv
// Elastic valid/ready pipeline register chain with clock-enable stall and synchronous flush.
// Optional one-entry input skid buffer enabled by defining PIPE_REG_SKID_EN.
module pipe_reg_elastic #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          ce,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(DEPTH+2)-1:0]    count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 2);

  logic [DEPTH-1:0]            stg_valid;
  logic [DEPTH-1:0][WIDTH-1:0] stg_data;
  logic [DEPTH-1:0]            rdy;
  logic                        adv;
  logic                        in_xfer;
  logic                        out_xfer;
  logic                        src_valid;
  logic [WIDTH-1:0]            src_data;

  // Stage k can load when any stage from k to the output is empty, or the output drains.
  always_comb begin : ready_chain
    logic all_full;
    all_full = 1'b1;
    rdy      = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      all_full = all_full & stg_valid[k];
      rdy[k]   = out_ready | ~all_full;
    end
  end

  assign adv       = ce & ~flush & clr_n;
  assign out_valid = stg_valid[DEPTH-1] & adv;
  assign out_data  = stg_data[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;

`ifdef PIPE_REG_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // in_ready depends only on the skid register, not on out_ready.
  assign in_ready  = adv & ~skid_valid;
  assign in_xfer   = in_valid & in_ready;
  assign src_valid = skid_valid | in_xfer;
  assign src_data  = skid_valid ? skid_data : in_data;

  always_ff @(posedge clk) begin
    if (!clr_n || flush) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (ce) begin
      if (skid_valid) begin
        if (rdy[0]) skid_valid <= 1'b0;
      end else if (in_xfer && !rdy[0]) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end
`else
  assign in_ready  = rdy[0] & adv;
  assign in_xfer   = in_valid & in_ready;
  assign src_valid = in_xfer;
  assign src_data  = in_data;
`endif

  // Register chain: each stage takes its predecessor's word whenever it is ready.
  always_ff @(posedge clk) begin
    if (!clr_n || flush) begin
      stg_valid <= '0;
      stg_data  <= '0;
    end else if (ce) begin
      if (rdy[0]) begin
        stg_valid[0] <= src_valid;
        if (src_valid) stg_data[0] <= src_data;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (rdy[k]) begin
          stg_valid[k] <= stg_valid[k-1];
          if (stg_valid[k-1]) stg_data[k] <= stg_data[k-1];
        end
      end
    end
  end

  // Occupancy counter tracks accepted-but-not-delivered words.
  always_ff @(posedge clk) begin
    if (!clr_n || flush) begin
      count <= '0;
    end else if (ce) begin
      case ({in_xfer, out_xfer})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Scoreboard bench for pipe_reg_elastic, default (no-skid) build, WIDTH=32 DEPTH=3.
module tb_pipe_reg_elastic;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             ce = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [$clog2(DEPTH+2)-1:0] count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_ov_cyc = -1;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] held;

  pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr_n(clr_n), .ce(ce), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check handshakes, score transfers, check count after the edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ordy);
    logic exp_ir, ix, ox, active;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy;
    #1;
    active = ce & ~flush & clr_n;
    exp_ir = active & ((q.size() < int'(DEPTH)) | ordy);
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    if (!active || q.size() == 0) chk("out_valid_idle", 64'(out_valid), 64'(0));
    if (out_valid === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
    ix = in_valid & in_ready;
    ox = out_valid & out_ready;
    if (ox === 1'b1) begin
      if (q.size() == 0) chk("out_unexpected", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("out_data", 64'(out_data), 64'(q.pop_front()));
    end
    if (ix === 1'b1) q.push_back(d);
    if (!clr_n || flush) q.delete();
    @(posedge clk);
    #1;
    cyc++;
    chk("count", 64'(count), 64'(q.size()));
  endtask

  initial begin
    int c0;
    // Power-up reset.
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    clr_n = 1'b1;
    chk("reset_out_data", 64'(out_data), 64'(0));

    // Streaming with latency check.
    first_ov_cyc = -1;
    c0 = cyc;
    for (int i = 1; i <= 10; i++) step(1'b1, WIDTH'(i), 1'b1);
    chk("latency", 64'(first_ov_cyc - c0), 64'(DEPTH));

    // Back-pressure mid-stream, then resume.
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(20 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(40 + i), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Reset with pipe full.
    for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(60 + i), 1'b0);
    chk("full_before_reset", 64'(count), 64'(DEPTH));
    clr_n = 1'b0;
    step(1'b1, WIDTH'(99), 1'b1);
    clr_n = 1'b1;
    chk("reset_mid_out_data", 64'(out_data), 64'(0));
    chk("reset_mid_out_valid", 64'(out_valid), 64'(0));

    // Clock-enable stall with two words held.
    step(1'b1, WIDTH'(100), 1'b0);
    step(1'b1, WIDTH'(101), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    chk("pre_stall_valid", 64'(out_valid), 64'(1));
    chk("pre_stall_data", 64'(out_data), 64'(100));
    held = out_data;
    ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, WIDTH'(200 + i), 1'b1);
      chk("stall_hold", 64'(out_data), 64'(held));
    end
    ce = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Flush with pipe full and a word offered in the flush cycle.
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(300 + i), 1'b0);
    flush = 1'b1;
    step(1'b1, WIDTH'(32'hDEAD), 1'b1);
    flush = 1'b0;
    chk("flush_out_data", 64'(out_data), 64'(0));
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(400 + i), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Random valid/ready traffic.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < int'(DEPTH) + 2; i++) step(1'b0, '0, 1'b1);
    chk("drained", 64'(q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
